// File: rtl/mmio_input_port.sv
// mmio_input_port: memory-mapped switch/button responder with a debounced press-event FIFO
// Sits beside data RAM on the dmem bus and answers the BASE_ADDR..BASE_ADDR+3 window.
module mmio_input_port #(
    parameter logic [11:0] BASE_ADDR       = 12'hFF0,
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter int          FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [11:0] io_addr,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    input  logic [15:0] SW,
    input  logic        BTNR,
    output logic        event_pending
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    logic [15:0]   sw_meta, sw_sync;
    logic          btn_meta, btn_sync, btn_db, btn_db_q;
    logic [CW-1:0] db_cnt;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count, count_n;
    logic          overflow;
    logic [11:0]   off;
    logic          in_win, rd_hit, wr_hit, push, push_ok, pop, flush, ovf_clr, unused_wdata;
    logic [31:0]   rd_mux;

    assign unused_wdata = ^{io_wdata[31:6], io_wdata[4:0]};

    always_comb begin
        off     = io_addr - BASE_ADDR;
        in_win  = off < 12'd4;
        rd_hit  = io_rd && in_win;
        wr_hit  = io_wr && in_win;
        push    = btn_db && !btn_db_q;
        pop     = rd_hit && off[1:0] == 2'd1 && count != '0;
        flush   = wr_hit && off[1:0] == 2'd3;
        ovf_clr = wr_hit && off[1:0] == 2'd0 && io_wdata[5];
        // a pop or flush in the same cycle frees the slot a full FIFO needs
        push_ok = push && (flush || pop || count != FULL);
        count_n = flush ? (AW+1)'(push) : count + (AW+1)'(push_ok) - (AW+1)'(pop);
        rd_mux  = off[1:0] == 2'd0 ? {25'b0, btn_db, overflow, 5'(count)} :
                  off[1:0] == 2'd1 ? (count != '0 ? {1'b1, 15'b0, mem[rd_ptr]} : 32'h0) :
                  off[1:0] == 2'd2 ? {16'b0, sw_sync} : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta       <= '0;
            sw_sync       <= '0;
            btn_meta      <= 1'b0;
            btn_sync      <= 1'b0;
            btn_db        <= 1'b0;
            btn_db_q      <= 1'b0;
            db_cnt        <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            overflow      <= 1'b0;
            event_pending <= 1'b0;
            io_rdata      <= '0;
        end else begin
            sw_meta       <= SW;
            sw_sync       <= sw_meta;
            btn_meta      <= BTNR;
            btn_sync      <= btn_meta;
            db_cnt        <= (btn_sync == btn_db || db_cnt == DB_LAST) ? '0 : db_cnt + CW'(1);
            btn_db        <= btn_db ^ (btn_sync != btn_db && db_cnt == DB_LAST);
            btn_db_q      <= btn_db;
            wr_ptr        <= wr_ptr + AW'(push_ok);
            rd_ptr        <= flush ? wr_ptr : rd_ptr + AW'(pop);
            count         <= count_n;
            overflow      <= (overflow && !ovf_clr) || (push && !push_ok);
            event_pending <= count_n != '0;
            if (rd_hit)
                io_rdata <= rd_mux;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= sw_sync;
    end
endmodule

// File: doc/mmio_input_port.md
# mmio_input_port

Memory-mapped input responder that answers processor data-memory accesses in a small I/O address window. It synchronizes the board switches (SW) and debounces the right button (BTNR). On each debounced press it captures a switch snapshot into a small event FIFO, which the processor drains with clear-on-read loads. It sits beside the data RAM on the processor's dmem bus; address decode selects it instead of RAM for the I/O window.

## Interface
- BASE_ADDR, 12'hFF0: word address of register 0; the block owns BASE_ADDR..BASE_ADDR+3.
- DEBOUNCE_CYCLES, 1000000: cycles BTNR must be stable before the debounced level changes (10 ms at 100 MHz).
- FIFO_DEPTH, 4: event FIFO entries; must be a power of two, 2..16.
- clock, input, 1: single system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset (clears all state while 0).
- io_rd, input, 1: one-cycle read strobe from the processor load path.
- io_wr, input, 1: one-cycle write strobe (processor wren qualified by the address decode).
- io_addr, input, 12: dmem word address.
- io_wdata, input, 32: store data.
- io_rdata, output, 32: read data, registered.
- SW, input, 16: raw, asynchronous board switches.
- BTNR, input, 1: raw, asynchronous button.
- event_pending, output, 1: high while the FIFO is non-empty.

## Operation
- **Input synchronization.** SW and BTNR each pass through a 2-flop synchronizer, giving sw_sync and btn_sync.
- **Debounce.**
  - A counter compares btn_sync against the debounced level btn_db.
  - On mismatch, the counter increments. On match, it clears to 0.
  - When the count reaches DEBOUNCE_CYCLES-1 while still mismatched, btn_db toggles and the counter clears.
  - The counter is sized to ceil(log2(DEBOUNCE_CYCLES))+1 bits.
- **Press event.** A press event is a btn_db rising edge (0->1). Releases generate no event.
- **Push.** A press event pushes {1'b1, 15'b0, sw_sync[15:0]} into the FIFO.
  - sw_sync is sampled in the same cycle btn_db rises.
  - Bit 31 of a pushed entry is the valid bit.
- **Register map** (a read of an address outside the window returns nothing and has no effect):
  - BASE+0 STATUS, read: [4:0] FIFO count, [5] overflow (sticky), [6] btn_db, others 0. No side effects.
  - BASE+0, write: if io_wdata[5]=1, clear overflow. Other bits are ignored.
  - BASE+1 EVENT, read: return the FIFO head and pop it. If the FIFO is empty, return 32'h0 and do not pop.
  - BASE+2 SWITCH, read: {16'b0, sw_sync}. No side effects.
  - BASE+3 FLUSH, write (any data): empty the FIFO. Overflow is unchanged.
  - Writes to BASE+1 and BASE+2 are ignored.
  - Reads of BASE+3 return 0.
- **Boundary behaviour.**
  - Push while full, no pop: the entry is dropped and overflow is set.
  - Push and pop in the same cycle while full: pop the head, accept the push, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: the pop returns 0 and the push is stored, so count becomes 1.
  - Flush and push in the same cycle: flush wins, then the push is stored, so count becomes 1.
  - io_rd and io_wr asserted together: both take effect. The write is applied after the read data is captured.
  - FIFO pointers wrap modulo FIFO_DEPTH. Count runs 0..FIFO_DEPTH inclusive.

## Timing
- **Reset values.** All state clears asynchronously when reset=0:
  - io_rdata=0, event_pending=0.
  - FIFO empty, overflow=0, btn_db=0, debounce counter=0, synchronizers=0.
- **Read latency.** io_rdata is registered. Data for an io_rd sampled at edge N is valid after edge N and holds until the next io_rd, which matches the RAM's one-cycle latency.
  - io_rdata updates only on io_rd cycles.
  - An io_rd outside the window leaves io_rdata unchanged.
- **Pop timing.** The pop takes effect at the same edge as the read. A STATUS read in the following cycle shows the decremented count.
- **Press-to-push latency.** A clean BTNR rise reaches the FIFO after 2 (sync) + DEBOUNCE_CYCLES (stable) + 1 (edge detect/push) cycles.
- **event_pending** is registered from the post-edge count, so it is valid the cycle after a push or pop.
- **Bounce.** A BTNR glitch shorter than DEBOUNCE_CYCLES produces no event and no btn_db change.
- **Reset mid-operation.** A partially debounced press is discarded. A read issued in the reset cycle returns 0.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, BASE_ADDR=12'hFF0.
- **Reset.** Hold reset=0 with random inputs -> io_rdata=0 and event_pending=0. Release reset, then read 0xFF0 -> 32'h0.
- **Single press.** SW=16'hA5C3, hold BTNR high for 10 cycles -> push 7 cycles after the rise; event_pending=1; read 0xFF0 -> count=1, bit6=1. Read 0xFF1 -> 32'h8000A5C3. Next read of 0xFF1 -> 32'h0; event_pending drops.
- **Bounce rejection.** Toggle BTNR high/low every 2 cycles for 40 cycles -> no push, count=0, btn_db=0.
- **Overflow.** Make 5 presses with SW=1,2,3,4,5 -> count=4, overflow=1. Pops return 0x80000001..0x80000004 in order. Write 0x20 to 0xFF0 -> overflow=0.
- **Full plus simultaneous pop/push.** Fill to 4, then align a pop of 0xFF1 with the push cycle of a 5th press -> count stays 4, overflow=0, and the last entry is the 5th snapshot.
- **Flush and switch read.** Push 3 events, write 0xFF3 -> count=0, event_pending=0. Set SW=16'h1234 and read 0xFF2 -> 32'h00001234 (2+ cycles after the SW change).
